// File: rtl/upd1771c_audio_out.sv
// Audio back end for the uPD1771C: box-car decimation of the sign-magnitude PCM stream,
// a 2^n gain with saturation and an optional one-pole DC blocker, producing a strobed 16-bit sample.
module upd1771c_audio_out #(
    parameter int DECIM_LOG2 = 7,
    parameter int DC_EN      = 1,
    parameter int DC_SHIFT   = 10
) (
    input  logic               CLK,
    input  logic               RESB,
    input  logic               CE,
    input  logic               PCM_NEG,
    input  logic [7:0]         PCM_OUT,
    input  logic               MUTE,
    input  logic [1:0]         GAIN,
    output logic signed [15:0] AUD_OUT,
    output logic               AUD_STB
);
    localparam int AW = 9 + DECIM_LOG2;

    function automatic logic signed [15:0] sat16(input logic signed [21:0] v);
        if (v > 22'sd32767)
            return 16'sh7FFF;
        else if (v < -22'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // S0: sign-magnitude to two's complement
    logic signed [8:0] w_s;
    logic signed [8:0] r_s;
    logic              r_s_v;

    always_comb begin
        w_s = '0;
        if (!MUTE)
            w_s = PCM_NEG ? -$signed({1'b0, PCM_OUT}) : $signed({1'b0, PCM_OUT});
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_s   <= '0;
            r_s_v <= 1'b0;
        end else begin
            r_s_v <= CE;
            if (CE)
                r_s <= w_s;
        end
    end

    // S1: window accumulator; the top 9 bits of the closing sum are the floored average
    logic signed [AW-1:0]     r_acc;
    logic [DECIM_LOG2-1:0]    r_cnt;
    logic signed [8:0]        r_avg;
    logic                     r_avg_v;
    logic signed [AW-1:0]     w_sum;

    assign w_sum = r_acc + {{(AW-9){r_s[8]}}, r_s};

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_avg   <= '0;
            r_avg_v <= 1'b0;
        end else begin
            r_avg_v <= 1'b0;
            if (r_s_v) begin
                r_cnt <= r_cnt + 1'b1;
                if (&r_cnt) begin
                    r_avg   <= w_sum[DECIM_LOG2 +: 9];
                    r_avg_v <= 1'b1;
                    r_acc   <= '0;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    // S2: gain; 255 << 10 still fits 20 signed bits, so the shift cannot wrap before saturation
    logic signed [19:0] w_wide;
    logic signed [15:0] r_x;
    logic               r_x_v;

    assign w_wide = 20'(r_avg) <<< (4'd7 + {2'b00, GAIN});

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_x   <= '0;
            r_x_v <= 1'b0;
        end else begin
            r_x_v <= r_avg_v;
            if (r_avg_v)
                r_x <= sat16(22'(w_wide));
        end
    end

    // S3: output register, optionally through the DC blocker
    generate
        if (DC_EN != 0) begin : g_dc
            logic signed [15:0] r_x_prev;
            logic signed [19:0] r_y;
            logic signed [21:0] w_y_new;
            logic signed [19:0] w_y_clamp;

            assign w_y_new = 22'(r_x) - 22'(r_x_prev) + 22'(r_y) - 22'(r_y >>> DC_SHIFT);

            always_comb begin
                w_y_clamp = w_y_new[19:0];
                if (w_y_new > 22'sd524287)
                    w_y_clamp = 20'sh7FFFF;
                else if (w_y_new < -22'sd524288)
                    w_y_clamp = 20'sh80000;
            end

            always_ff @(posedge CLK or negedge RESB) begin
                if (!RESB) begin
                    r_x_prev <= '0;
                    r_y      <= '0;
                    AUD_OUT  <= '0;
                    AUD_STB  <= 1'b0;
                end else begin
                    AUD_STB <= r_x_v;
                    if (r_x_v) begin
                        r_x_prev <= r_x;
                        r_y      <= w_y_clamp;
                        AUD_OUT  <= sat16(w_y_new);
                    end
                end
            end
        end else begin : g_pass
            always_ff @(posedge CLK or negedge RESB) begin
                if (!RESB) begin
                    AUD_OUT <= '0;
                    AUD_STB <= 1'b0;
                end else begin
                    AUD_STB <= r_x_v;
                    if (r_x_v)
                        AUD_OUT <= r_x;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_upd1771c_audio_out.sv
// Scoreboard bench: stimulus pushes hand-computed samples and strobe cycles, monitors pop and compare.
module tb_upd1771c_audio_out;
    logic               CLK = 1'b0;
    logic               RESB = 1'b0;
    logic               CE = 1'b0;
    logic               PCM_NEG = 1'b0;
    logic [7:0]         PCM_OUT = '0;
    logic               MUTE = 1'b0;
    logic [1:0]         GAIN = '0;
    logic signed [15:0] aud_main, aud_dc;
    logic               stb_main, stb_dc;

    upd1771c_audio_out #(.DECIM_LOG2(2), .DC_EN(0), .DC_SHIFT(4)) u_main (
        .CLK(CLK), .RESB(RESB), .CE(CE), .PCM_NEG(PCM_NEG), .PCM_OUT(PCM_OUT),
        .MUTE(MUTE), .GAIN(GAIN), .AUD_OUT(aud_main), .AUD_STB(stb_main));

    upd1771c_audio_out #(.DECIM_LOG2(2), .DC_EN(1), .DC_SHIFT(4)) u_dc (
        .CLK(CLK), .RESB(RESB), .CE(CE), .PCM_NEG(PCM_NEG), .PCM_OUT(PCM_OUT),
        .MUTE(MUTE), .GAIN(GAIN), .AUD_OUT(aud_dc), .AUD_STB(stb_dc));

    always #5 CLK = ~CLK;

    typedef struct {
        logic signed [15:0] val;
        int                 cyc;
    } exp_t;

    exp_t q_main[$];
    exp_t q_dc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   dc_active = 1'b0;
    logic signed [15:0] last_main = '0;
    logic signed [15:0] last_dc = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    endtask

    // Monitors: strobes pop the scoreboard, quiet cycles must hold the last value
    always @(negedge CLK) begin
        exp_t e;
        if (!RESB) begin
            chk("rst_main_out", aud_main, 0);
            chk("rst_main_stb", stb_main, 0);
            chk("rst_dc_out", aud_dc, 0);
            chk("rst_dc_stb", stb_dc, 0);
            last_main = '0;
            last_dc   = '0;
        end else begin
            if (stb_main) begin
                if (q_main.size() == 0) begin
                    chk("main_spurious_stb", 1, 0);
                end else begin
                    e = q_main.pop_front();
                    $display("main strobe cyc=%0d out=%0d exp=%0d", cyc, aud_main, e.val);
                    chk("main_value", aud_main, e.val);
                    chk("main_stb_cycle", cyc, e.cyc);
                    last_main = e.val;
                end
            end else begin
                chk("main_hold", aud_main, last_main);
            end
            if (dc_active) begin
                if (stb_dc) begin
                    if (q_dc.size() == 0) begin
                        chk("dc_spurious_stb", 1, 0);
                    end else begin
                        e = q_dc.pop_front();
                        $display("dc strobe cyc=%0d out=%0d exp=%0d", cyc, aud_dc, e.val);
                        chk("dc_value", aud_dc, e.val);
                        chk("dc_stb_cycle", cyc, e.cyc);
                        last_dc = e.val;
                    end
                end else begin
                    chk("dc_hold", aud_dc, last_dc);
                end
            end
        end
    end

    task automatic drive(input logic ce, input logic neg, input logic [7:0] mag, input logic mute);
        @(posedge CLK);
        #1;
        CE = ce;
        PCM_NEG = neg;
        PCM_OUT = mag;
        MUTE = mute;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            drive(1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    // One window of 4 samples; gap = CE-low cycles after each sample
    task automatic run_window(input logic [3:0] negs, input logic [31:0] mags, input logic [3:0] mutes,
                              input int gap, input logic signed [15:0] exp_main,
                              input logic signed [15:0] exp_dc);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, negs[i], mags[8*i +: 8], mutes[i]);
            if (i == 3) begin
                e.cyc = cyc + 4;
                e.val = exp_main;
                q_main.push_back(e);
                if (dc_active) begin
                    e.val = exp_dc;
                    q_dc.push_back(e);
                end
            end
            for (int g = 0; g < gap; g++)
                drive(1'b0, 1'b0, 8'd0, 1'b0);
        end
    endtask

    task automatic set_gain(input logic [1:0] g);
        idle(6);
        GAIN = g;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RESB = 1'b1;

        // Constant 100, back-to-back windows: period 4, latency 3 edges
        for (int w = 0; w < 3; w++)
            run_window(4'b0000, {4{8'd100}}, 4'b0000, 0, 16'sd12800, 16'sd0);
        run_window(4'b0000, {8'd200, 8'd0, 8'd200, 8'd0}, 4'b0000, 0, 16'sd12800, 16'sd0);
        run_window(4'b1111, {4{8'd0}}, 4'b0000, 0, 16'sd0, 16'sd0);
        run_window(4'b1111, {4{8'd3}}, 4'b0000, 0, -16'sd384, 16'sd0);
        run_window(4'b0001, {8'd0, 8'd0, 8'd0, 8'd1}, 4'b0000, 0, -16'sd128, 16'sd0);
        run_window(4'b0000, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0000, 0, 16'sd0, 16'sd0);

        set_gain(2'd3);
        run_window(4'b0000, {4{8'd255}}, 4'b0000, 0, 16'sd32767, 16'sd0);
        run_window(4'b1111, {4{8'd255}}, 4'b0000, 0, -16'sd32768, 16'sd0);
        run_window(4'b0000, {4{8'd31}}, 4'b0000, 0, 16'sd31744, 16'sd0);
        run_window(4'b0000, {4{8'd32}}, 4'b0000, 0, 16'sd32767, 16'sd0);
        run_window(4'b1111, {4{8'd32}}, 4'b0000, 0, -16'sd32768, 16'sd0);
        set_gain(2'd2);
        run_window(4'b0000, {4{8'd255}}, 4'b0000, 0, 16'sd32767, 16'sd0);
        set_gain(2'd1);
        run_window(4'b0000, {4{8'd100}}, 4'b0000, 0, 16'sd25600, 16'sd0);

        // CE every other cycle, then MUTE over the last two samples
        set_gain(2'd0);
        run_window(4'b0000, {4{8'd100}}, 4'b0000, 1, 16'sd12800, 16'sd0);
        run_window(4'b0000, {4{8'd100}}, 4'b0000, 1, 16'sd12800, 16'sd0);
        run_window(4'b0000, {4{8'd100}}, 4'b1100, 0, 16'sd6400, 16'sd0);

        // Reset during the 3rd sample; the DC instance is checked from here on
        idle(8);
        drive(1'b1, 1'b0, 8'd100, 1'b0);
        drive(1'b1, 1'b0, 8'd100, 1'b0);
        drive(1'b1, 1'b0, 8'd100, 1'b0);
        RESB = 1'b0;
        dc_active = 1'b1;
        @(posedge CLK);
        #1;
        RESB = 1'b1;
        CE = 1'b0;
        run_window(4'b0000, {4{8'd100}}, 4'b0000, 0, 16'sd12800, 16'sd12800);
        run_window(4'b0000, {4{8'd100}}, 4'b0000, 0, 16'sd12800, 16'sd12000);
        run_window(4'b0000, {4{8'd100}}, 4'b0000, 0, 16'sd12800, 16'sd11250);
        run_window(4'b0000, {4{8'd100}}, 4'b0000, 0, 16'sd12800, 16'sd10547);
        run_window(4'b0000, {4{8'd100}}, 4'b0000, 0, 16'sd12800, 16'sd9888);

        idle(1);
        for (int i = 0; i < 40 && (q_main.size() != 0 || q_dc.size() != 0); i++)
            @(posedge CLK);
        idle(4);
        chk("main_queue_drained", q_main.size(), 0);
        chk("dc_queue_drained", q_dc.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
